// File: rtl/bus_pkg.sv
// Shared state/cycle encodings and default limits for the bus cycle controller.
package bus_pkg;

    localparam int FORCED_WAITS_DEF = 0;
    localparam int TIMEOUT_DEF      = 255;
    localparam int CNT_W            = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TW   = 3'd3,
        T3   = 3'd4,
        HOLD = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        MEM_RD = 2'b00,
        MEM_WR = 2'b01,
        IO_RD  = 2'b10,
        IO_WR  = 2'b11
    } cycle_t;

    function automatic cycle_t make_cycle(input logic io, input logic wr);
        cycle_t c;
        c = MEM_RD;
        if (io && wr)
            c = IO_WR;
        else if (io)
            c = IO_RD;
        else if (wr)
            c = MEM_WR;
        return c;
    endfunction

    function automatic logic cycle_is_write(input cycle_t c);
        return (c == MEM_WR) || (c == IO_WR);
    endfunction

    function automatic logic cycle_is_io(input cycle_t c);
        return (c == IO_RD) || (c == IO_WR);
    endfunction

endpackage

// File: rtl/bus_wait_cnt.sv
// Wait-state bookkeeping: forced-wait count and consecutive not-ready (timeout) count.
module bus_wait_cnt
    import bus_pkg::*;
#(
    parameter int FORCED_WAITS = FORCED_WAITS_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    input  logic ready,
    output logic forced_done,
    output logic timeout
);

    localparam logic [CNT_W:0] FW_LIM = (CNT_W+1)'(FORCED_WAITS);
    localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W:0]   wait_next, stall_next;

    // Outputs look at the count including the TW state currently in progress.
    always_comb begin
        wait_next   = {1'b0, wait_cnt_q} + {{CNT_W{1'b0}}, inc};
        stall_next  = {1'b0, stall_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        forced_done = (wait_next >= FW_LIM);
        timeout     = inc && !ready && (stall_next >= TO_LIM);

        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (clear) begin
            wait_cnt_d  = '0;
            stall_cnt_d = '0;
        end else if (inc) begin
            wait_cnt_d  = wait_next[CNT_W] ? {CNT_W{1'b1}} : wait_next[CNT_W-1:0];
            if (ready)
                stall_cnt_d = '0;
            else
                stall_cnt_d = stall_next[CNT_W] ? {CNT_W{1'b1}} : stall_next[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 8085-style machine-cycle sequencer (T1/T2/TW/T3) with multiplexed AD bus and HOLD/HLDA.
module bus_cycle_ctrl
    import bus_pkg::*;
#(
    parameter int FORCED_WAITS = FORCED_WAITS_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_wr,
    input  logic        req_io,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rdata,
    inout  wire  [7:0]  adad,
    output logic [7:0]  a_hi,
    output logic        ale,
    output logic        rd_n,
    output logic        wr_n,
    output logic        io_m,
    input  logic        ready,
    input  logic        hold,
    output logic        hlda
);

    state_t      state_q, state_d;
    cycle_t      cyc_q, cyc_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic        ack_q, ack_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic        ale_q, ale_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic        io_m_q, io_m_d, hlda_q, hlda_d;
    logic        adad_oe_q, adad_oe_d;
    logic [7:0]  adad_out_q, adad_out_d, a_hi_q, a_hi_d, rdata_q, rdata_d;

    logic        start, finish, abort, strobe_d, is_wr_d;
    logic        forced_done, timeout;

    bus_wait_cnt #(
        .FORCED_WAITS (FORCED_WAITS),
        .TIMEOUT      (TIMEOUT)
    ) u_wait_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear       (state_q == T1),
        .inc         (state_q == TW),
        .ready       (ready),
        .forced_done (forced_done),
        .timeout     (timeout)
    );

    // Next state first; every registered output is then decoded from the state being entered.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        start   = 1'b0;
        finish  = 1'b0;
        abort   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hold)
                    state_d = HOLD;
                else if (req) begin
                    state_d = T1;
                    start   = 1'b1;
                end
            end
            T1:   state_d = T2;
            T2, TW: begin
                if (timeout) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (!forced_done || !ready)
                    state_d = TW;
                else
                    state_d = T3;
            end
            T3: begin
                finish = 1'b1;
                if (hold)
                    state_d = HOLD;
                else if (req) begin
                    state_d = T1;
                    start   = 1'b1;
                end else
                    state_d = IDLE;
            end
            HOLD: begin
                if (!hold)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            cyc_d   = make_cycle(req_io, req_wr);
        end

        strobe_d   = (state_d == T2) || (state_d == TW) || (state_d == T3);
        is_wr_d    = cycle_is_write(cyc_d);
        ack_d      = start;
        done_d     = finish || abort;
        err_d      = abort;
        rdata_d    = (finish && !cycle_is_write(cyc_q)) ? adad : rdata_q;
        busy_d     = (state_d == T1) || strobe_d;
        hlda_d     = (state_d == HOLD);
        ale_d      = (state_d == T1);
        rd_n_d     = !(strobe_d && !is_wr_d);
        wr_n_d     = !(strobe_d && is_wr_d);
        a_hi_d     = ale_d ? addr_d[15:8] : a_hi_q;
        io_m_d     = ale_d ? cycle_is_io(cyc_d) : io_m_q;
        adad_oe_d  = ale_d || (strobe_d && is_wr_d);
        adad_out_d = ale_d ? addr_d[7:0] : wdata_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cyc_q      <= MEM_RD;
            addr_q     <= '0;
            wdata_q    <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            hlda_q     <= 1'b0;
            ale_q      <= 1'b0;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            a_hi_q     <= '0;
            io_m_q     <= 1'b0;
            adad_oe_q  <= 1'b0;
            adad_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            hlda_q     <= hlda_d;
            ale_q      <= ale_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            a_hi_q     <= a_hi_d;
            io_m_q     <= io_m_d;
            adad_oe_q  <= adad_oe_d;
            adad_out_q <= adad_out_d;
        end
    end

    assign adad  = adad_oe_q ? adad_out_q : 8'hzz;
    assign ack   = ack_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign rdata = rdata_q;
    assign hlda  = hlda_q;
    assign ale   = ale_q;
    assign rd_n  = rd_n_q;
    assign wr_n  = wr_n_q;
    assign a_hi  = a_hi_q;
    assign io_m  = io_m_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed self-checking bench for bus_cycle_ctrl (TIMEOUT=4 instance plus a FORCED_WAITS=2 instance).
module tb_bus_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, req_wr, req_io, ready, hold;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic [7:0]  slave_data;

    logic        ack, busy, done, err, ale, rd_n, wr_n, io_m, hlda;
    logic [7:0]  rdata, a_hi;
    wire  [7:0]  adad;

    logic        ack_fw, busy_fw, done_fw, err_fw, ale_fw, rd_fw_n, wr_fw_n, io_m_fw, hlda_fw;
    logic [7:0]  rdata_fw, a_hi_fw;
    wire  [7:0]  adad_fw;

    int n_compared;
    int n_mismatched;

    int strobe_low, done_at, done_cnt, err_cnt, ale_cnt;

    always #5 clk = ~clk;

    // Slave drives the bus during read strobes and while the bus is granted away.
    assign adad    = (!rd_n || hlda) ? slave_data : 8'hzz;
    assign adad_fw = (!rd_fw_n) ? slave_data : 8'hzz;

    bus_cycle_ctrl #(.FORCED_WAITS(0), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_io(req_io),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .busy(busy),
        .done(done), .err(err), .rdata(rdata), .adad(adad), .a_hi(a_hi),
        .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .io_m(io_m), .ready(ready),
        .hold(hold), .hlda(hlda)
    );

    bus_cycle_ctrl #(.FORCED_WAITS(2), .TIMEOUT(255)) dut_fw (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_io(req_io),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack_fw), .busy(busy_fw),
        .done(done_fw), .err(err_fw), .rdata(rdata_fw), .adad(adad_fw), .a_hi(a_hi_fw),
        .ale(ale_fw), .rd_n(rd_fw_n), .wr_n(wr_fw_n), .io_m(io_m_fw), .ready(ready),
        .hold(hold), .hlda(hlda_fw)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic wr, input logic io, input logic [15:0] addr,
                                 input logic [7:0] wd, input logic rdy, input logic hl);
        req       = r;
        req_wr    = wr;
        req_io    = io;
        req_addr  = addr;
        req_wdata = wd;
        ready     = rdy;
        hold      = hl;
    endtask

    task automatic waitAck(input string tag);
        int budget;
        budget = 0;
        @(negedge clk);
        while (ack !== 1'b1 && budget < 8) begin
            @(negedge clk);
            budget++;
        end
        checkOutput({tag, "_ack"}, {15'd0, ack}, 16'd1);
    endtask

    // One full cycle: T1 checks at the ack, then per-cycle strobe/bus checks and counters.
    task automatic runCycle(input string tag, input logic wr, input logic io, input logic [15:0] addr,
                            input logic [7:0] wd, input int ready_low);
        applyStimulus(1'b1, wr, io, addr, wd, 1'b1, 1'b0);
        waitAck(tag);
        checkOutput({tag, "_t1_adad"}, {8'h00, adad}, {8'h00, addr[7:0]});
        checkOutput({tag, "_t1_ahi"}, {8'h00, a_hi}, {8'h00, addr[15:8]});
        checkOutput({tag, "_t1_iom"}, {15'd0, io_m}, {15'd0, io});
        req        = 1'b0;
        strobe_low = 0;
        done_at    = -1;
        done_cnt   = 0;
        err_cnt    = 0;
        ale_cnt    = 0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (ale === 1'b1) ale_cnt++;
            if (rd_n === 1'b0 || wr_n === 1'b0) strobe_low++;
            if (rd_n === 1'b0) checkOutput({tag, "_rd_bus"}, {8'h00, adad}, {8'h00, slave_data});
            if (wr_n === 1'b0) checkOutput({tag, "_wr_bus"}, {8'h00, adad}, {8'h00, wd});
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (err === 1'b1) err_cnt++;
            ready = (k > ready_low);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        slave_data   = 8'h00;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_ctrl", {7'd0, ale, rd_n, wr_n, io_m, ack, busy, done, err, hlda}, 16'h00C0);
        checkOutput("rst_ahi", {8'h00, a_hi}, 16'h0000);
        checkOutput("rst_rdata", {8'h00, rdata}, 16'h0000);
        checkOutput("rst_fw_ctrl", {7'd0, ale_fw, rd_fw_n, wr_fw_n, io_m_fw, ack_fw, busy_fw, done_fw, err_fw, hlda_fw}, 16'h00C0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_busy", {15'd0, busy}, 16'd0);

        $display("[TB] memory read 0x20F3");
        slave_data = 8'h5A;
        runCycle("mrd", 1'b0, 1'b0, 16'h20F3, 8'h00, 0);
        checkOutput("mrd_ale_cnt", 16'(ale_cnt), 16'd1);
        checkOutput("mrd_strobe", 16'(strobe_low), 16'd2);
        checkOutput("mrd_done_at", 16'(done_at), 16'd3);
        checkOutput("mrd_done_cnt", 16'(done_cnt), 16'd1);
        checkOutput("mrd_err_cnt", 16'(err_cnt), 16'd0);
        checkOutput("mrd_rdata", {8'h00, rdata}, 16'h005A);
        checkOutput("mrd_rdn_end", {15'd0, rd_n}, 16'd1);

        $display("[TB] io write 0x0042 with 3 wait states");
        runCycle("iowr", 1'b1, 1'b1, 16'h0042, 8'hC3, 3);
        checkOutput("iowr_strobe", 16'(strobe_low), 16'd5);
        checkOutput("iowr_done_at", 16'(done_at), 16'd6);
        checkOutput("iowr_done_cnt", 16'(done_cnt), 16'd1);
        checkOutput("iowr_err_cnt", 16'(err_cnt), 16'd0);
        checkOutput("iowr_iom", {15'd0, io_m}, 16'd1);
        checkOutput("iowr_rdata_kept", {8'h00, rdata}, 16'h005A);

        $display("[TB] back-to-back read then write");
        slave_data = 8'hA5;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234, 8'h00, 1'b1, 1'b0);
        waitAck("b2b1");
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h5678, 8'h3C, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("b2b_t2_bus", {7'd0, rd_n, adad}, 16'h00A5);
        @(negedge clk);
        checkOutput("b2b_t3", {14'd0, done, rd_n}, 16'd0);
        @(negedge clk);
        checkOutput("b2b_overlap", {12'd0, done, ack, ale, busy}, 16'h000F);
        checkOutput("b2b_rdata", {8'h00, rdata}, 16'h00A5);
        checkOutput("b2b_t1_addr", {a_hi, adad}, 16'h5678);
        req = 1'b0;
        @(negedge clk);
        checkOutput("b2b_wr_bus", {7'd0, wr_n, adad}, 16'h003C);
        @(negedge clk);
        @(negedge clk);
        checkOutput("b2b_done2", {12'd0, done, err, wr_n, ack}, 16'b1010);

        $display("[TB] hold and req together");
        slave_data = 8'h11;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h00AA, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("hold_ctrl", {10'd0, hlda, ack, busy, ale, rd_n, wr_n}, 16'b100011);
        checkOutput("hold_bus", {8'h00, adad}, 16'h0011);
        @(negedge clk);
        checkOutput("hold_stay", {15'd0, hlda}, 16'd1);
        hold = 1'b0;
        @(negedge clk);
        checkOutput("hold_release", {14'd0, hlda, ack}, 16'd0);
        @(negedge clk);
        checkOutput("hold_ack", {15'd0, ack}, 16'd1);
        checkOutput("hold_t1_addr", {a_hi, adad}, 16'h00AA);
        req = 1'b0;
        @(negedge clk);
        checkOutput("hold_rd", {15'd0, rd_n}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("hold_done", {15'd0, done}, 16'd1);
        checkOutput("hold_rdata", {8'h00, rdata}, 16'h0011);

        $display("[TB] timeout with ready stuck low");
        slave_data = 8'h77;
        runCycle("tmo", 1'b0, 1'b0, 16'h1000, 8'h00, 100);
        ready = 1'b1;
        checkOutput("tmo_strobe", 16'(strobe_low), 16'd5);
        checkOutput("tmo_done_at", 16'(done_at), 16'd6);
        checkOutput("tmo_done_cnt", 16'(done_cnt), 16'd1);
        checkOutput("tmo_err_cnt", 16'(err_cnt), 16'd1);
        checkOutput("tmo_rdata_kept", {8'h00, rdata}, 16'h0011);
        checkOutput("tmo_rdn", {15'd0, rd_n}, 16'd1);

        $display("[TB] reset during wait state");
        slave_data = 8'h44;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h3333, 8'h00, 1'b0, 1'b0);
        waitAck("rstmid");
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstmid_tw", {14'd0, busy, rd_n}, 16'b10);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_abort", {11'd0, done, busy, rd_n, ack, err}, 16'b00100);
        rst   = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_nodone", {14'd0, done, busy}, 16'd0);
        checkOutput("rstmid_rdata", {8'h00, rdata}, 16'h0000);

        $display("[TB] forced wait states");
        slave_data = 8'h99;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0F0F, 8'h00, 1'b1, 1'b0);
        begin
            int budget;
            budget = 0;
            @(negedge clk);
            while (ack_fw !== 1'b1 && budget < 8) begin
                @(negedge clk);
                budget++;
            end
        end
        checkOutput("fw_ack", {15'd0, ack_fw}, 16'd1);
        req        = 1'b0;
        strobe_low = 0;
        done_at    = -1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (rd_fw_n === 1'b0) strobe_low++;
            if (done_fw === 1'b1 && done_at < 0) done_at = k;
        end
        checkOutput("fw_strobe", 16'(strobe_low), 16'd4);
        checkOutput("fw_done_at", 16'(done_at), 16'd5);
        checkOutput("fw_rdata", {8'h00, rdata_fw}, 16'h0099);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
